// File: rtl/scroll_display_driver.sv
// Scrolling 4-digit 7-segment driver; an/seg are registered, 1 cycle behind sel/offset.
// Loader never backpressures (char_ready tied high). Optional SCROLL_PAUSE_EN adds a pause input.
module scroll_display_driver #(
   parameter int DEPTH        = 16,
   parameter int REFRESH_BITS = 18
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       shift_signal,
`ifdef SCROLL_PAUSE_EN
   input  logic       pause,
`endif
   input  logic       char_valid,
   output logic       char_ready,
   input  logic [3:0] char_data,
   input  logic       char_last,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       busy_scroll
);
   localparam int IW = $clog2(DEPTH);
   localparam int LW = IW + 1;

   typedef enum logic [1:0] {IDLE, LOAD, SCROLL} state_t;

   state_t                  state;
   logic [IW-1:0]           wr_idx;
   logic [IW-1:0]           offset;
   logic [LW-1:0]           len;
   logic [REFRESH_BITS-1:0] refresh;
   logic [3:0]              mem [DEPTH];
   logic [1:0]              sel;
   logic [LW-1:0]           rd_sum;
   logic [IW-1:0]           wr_addr;
   logic                    accept;
   logic                    shift_en;

   function automatic logic [6:0] hexdecode(input logic [3:0] c);
      case (c)
         4'h0: hexdecode = 7'b1000000;
         4'h1: hexdecode = 7'b1111001;
         4'h2: hexdecode = 7'b0100100;
         4'h3: hexdecode = 7'b0110000;
         4'h4: hexdecode = 7'b0011001;
         4'h5: hexdecode = 7'b0010010;
         4'h6: hexdecode = 7'b0000010;
         4'h7: hexdecode = 7'b1111000;
         4'h8: hexdecode = 7'b0000000;
         4'h9: hexdecode = 7'b0010000;
         4'hA: hexdecode = 7'b0001000;
         4'hB: hexdecode = 7'b0000011;
         4'hC: hexdecode = 7'b1000110;
         4'hD: hexdecode = 7'b0100001;
         4'hE: hexdecode = 7'b0000110;
         default: hexdecode = 7'b0001110;
      endcase
   endfunction

   assign char_ready  = 1'b1;
   assign accept      = char_valid & char_ready;
   assign busy_scroll = (state == SCROLL);
   assign sel         = refresh[REFRESH_BITS-1 -: 2];
   assign wr_addr     = (state == LOAD) ? wr_idx : '0;

`ifdef SCROLL_PAUSE_EN
   assign shift_en = shift_signal & ~pause;
`else
   assign shift_en = shift_signal;
`endif

   // (offset + digit) mod len; sum stays below offset+4, so three folds cover len=1
   always_comb begin
      rd_sum = LW'(offset) + LW'(sel);
      for (int i = 0; i < 3; i++) begin
         if (rd_sum >= len) rd_sum = rd_sum - len;
      end
   end

   always_ff @(posedge clock) begin
      if (accept) mem[wr_addr] <= char_data;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         wr_idx  <= '0;
         len     <= '0;
         offset  <= '0;
         refresh <= '0;
         an      <= 4'b1111;
         seg     <= 7'b1111111;
      end else begin
         refresh <= refresh + 1'b1;

         if (state == SCROLL) begin
            an  <= ~(4'b1000 >> sel);
            seg <= hexdecode(mem[rd_sum[IW-1:0]]);
         end else begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
         end

         case (state)
            IDLE, SCROLL: begin
               // a new message wins over a coincident shift pulse
               if (accept) begin
                  wr_idx <= IW'(1);
                  offset <= '0;
                  if (char_last) begin
                     len   <= LW'(1);
                     state <= SCROLL;
                  end else begin
                     state <= LOAD;
                  end
               end else if (state == SCROLL && shift_en) begin
                  offset <= (LW'(offset) + LW'(1) == len) ? '0 : offset + 1'b1;
               end
            end
            LOAD: begin
               if (accept) begin
                  wr_idx <= wr_idx + 1'b1;
                  if (char_last || wr_idx == IW'(DEPTH - 1)) begin
                     len    <= LW'(wr_idx) + LW'(1);
                     offset <= '0;
                     state  <= SCROLL;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_scroll_display_driver.sv
// Bench for scroll_display_driver: per-cycle compare against a queue-based message model,
// decode table vectors, directed corner sequences and a randomized phase.
module tb_scroll_display_driver;
   localparam int DEPTH = 16;
   localparam int RB    = 4;
`ifdef SCROLL_PAUSE_EN
   localparam bit HAS_PAUSE = 1'b1;
`else
   localparam bit HAS_PAUSE = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset;
   logic       shift_signal;
   logic       char_valid;
   logic       char_ready;
   logic [3:0] char_data;
   logic       char_last;
   logic [3:0] an;
   logic [6:0] seg;
   logic       busy_scroll;
`ifdef SCROLL_PAUSE_EN
   logic       pause;
`endif

   typedef struct {
      logic [3:0] ch;
      logic [6:0] seg;
   } vec_t;
   vec_t vecs [16];

   int checks = 0;
   int errors = 0;
   int unsigned cyc = 0;

   int m_msg [$];
   int m_buf [$];
   bit m_scroll  = 1'b0;
   bit m_loading = 1'b0;
   int m_off     = 0;

   scroll_display_driver #(.DEPTH(DEPTH), .REFRESH_BITS(RB)) dut (
      .clock        (clock),
      .reset        (reset),
      .shift_signal (shift_signal),
`ifdef SCROLL_PAUSE_EN
      .pause        (pause),
`endif
      .char_valid   (char_valid),
      .char_ready   (char_ready),
      .char_data    (char_data),
      .char_last    (char_last),
      .an           (an),
      .seg          (seg),
      .busy_scroll  (busy_scroll)
   );

   always #5 clock = ~clock;

   // posedges since reset release == the DUT refresh count
   always @(posedge clock or negedge reset) begin
      if (!reset) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(input bit v, input int d, input bit l, input bit s, input bit p);
      if (v) begin
         if (!m_loading) m_buf = {};
         m_buf.push_back(d);
         m_off = 0;
         if (l || m_buf.size() == DEPTH) begin
            m_msg     = m_buf;
            m_scroll  = 1'b1;
            m_loading = 1'b0;
         end else begin
            m_scroll  = 1'b0;
            m_loading = 1'b1;
         end
      end else if (s && m_scroll && !(HAS_PAUSE && p)) begin
         m_off = (m_off + 1) % m_msg.size();
      end
   endtask

   // called at a negedge: drive, predict, cross one posedge, compare at the next negedge
   task automatic tick(input bit v, input logic [3:0] d, input bit l, input bit s, input bit p);
      int         k;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      char_valid   = v;
      char_data    = d;
      char_last    = l;
      shift_signal = s;
`ifdef SCROLL_PAUSE_EN
      pause = p;
`endif
      k = int'((cyc >> (RB - 2)) & 3);
      if (m_scroll) begin
         e_an  = ~(4'b1000 >> k);
         e_seg = vecs[m_msg[(m_off + k) % m_msg.size()]].seg;
      end else begin
         e_an  = 4'b1111;
         e_seg = 7'b1111111;
      end
      model_edge(v, int'(d), l, s, p);
      @(negedge clock);
      char_valid   = 1'b0;
      char_last    = 1'b0;
      shift_signal = 1'b0;
      chk("busy_scroll", 32'(busy_scroll), 32'(m_scroll));
      chk("an", 32'(an), 32'(e_an));
      chk("seg", 32'(seg), 32'(e_seg));
      chk("char_ready", 32'(char_ready), 32'(1'b1));
   endtask

   task automatic pulse();
      tick(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
   endtask

   // w holds the expected window, leftmost digit in the top nibble
   task automatic expect_window(input logic [15:0] w, input string name);
      logic [6:0] got [4];
      logic [3:0] ch;
      for (int j = 0; j < 4; j++) got[j] = 7'b1111111;
      for (int c = 0; c < 16; c++) begin
         tick(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
         for (int j = 0; j < 4; j++) if (an[3-j] == 1'b0) got[j] = seg;
      end
      for (int j = 0; j < 4; j++) begin
         ch = w[15-4*j -: 4];
         chk($sformatf("%s_d%0d", name, j), 32'(got[j]), 32'(vecs[ch].seg));
      end
   endtask

   task automatic load(input logic [63:0] w, input int n, input bit last);
      for (int i = 0; i < n; i++)
         tick(1'b1, w[4*(n-1-i) +: 4], last && (i == n - 1), 1'b0, 1'b0);
   endtask

   task automatic mid_reset(input string name);
      #2 reset = 1'b0;
      #1;
      chk({name, "_an"}, 32'(an), 32'(4'b1111));
      chk({name, "_seg"}, 32'(seg), 32'(7'b1111111));
      chk({name, "_busy"}, 32'(busy_scroll), 32'(1'b0));
      m_msg = {};
      m_buf = {};
      m_scroll  = 1'b0;
      m_loading = 1'b0;
      m_off     = 0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
   endtask

   initial begin
      logic [6:0] segs [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      for (int i = 0; i < 16; i++) begin
         vecs[i].ch  = 4'(i);
         vecs[i].seg = segs[i];
      end

      reset        = 1'b0;
      char_valid   = 1'b0;
      char_data    = 4'h0;
      char_last    = 1'b0;
      shift_signal = 1'b0;
`ifdef SCROLL_PAUSE_EN
      pause = 1'b0;
`endif
      repeat (3) @(negedge clock);
      chk("rst_an", 32'(an), 32'(4'b1111));
      chk("rst_seg", 32'(seg), 32'(7'b1111111));
      chk("rst_ready", 32'(char_ready), 32'(1'b1));
      chk("rst_busy", 32'(busy_scroll), 32'(1'b0));
      reset = 1'b1;
      repeat (6) tick(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
      chk("idle_dark_an", 32'(an), 32'(4'b1111));

      // load 1..5 and scroll with wrap at len=5
      load(64'h12345, 5, 1'b1);
      chk("busy_after_load", 32'(busy_scroll), 32'(1'b1));
      expect_window(16'h1234, "win_1234");
      pulse();
      expect_window(16'h2345, "win_2345");
      repeat (3) pulse();
      expect_window(16'h5123, "win_5123");

      // reach offset 2, then collide a new char with a shift pulse
      repeat (3) pulse();
      expect_window(16'h3451, "win_3451");
      tick(1'b1, 4'h9, 1'b0, 1'b1, 1'b0);
      chk("collide_busy", 32'(busy_scroll), 32'(1'b0));
      tick(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      chk("collide_dark", 32'(an), 32'(4'b1111));
      tick(1'b1, 4'h6, 1'b1, 1'b0, 1'b0);
      expect_window(16'h9696, "win_9696");

      // single-character messages through the decode table
      for (int i = 0; i < 16; i++) begin
         tick(1'b1, vecs[i].ch, 1'b1, 1'b0, 1'b0);
         expect_window({4{vecs[i].ch}}, $sformatf("single_%0h", i));
      end

      // full-length message without char_last
      load(64'hFEDCBA9876543210, 16, 1'b0);
      chk("full_busy", 32'(busy_scroll), 32'(1'b1));
      expect_window(16'hFEDC, "win_full0");
      repeat (15) pulse();
      expect_window(16'h0FED, "win_full15");
      pulse();
      tick(1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
      chk("char17_busy", 32'(busy_scroll), 32'(1'b0));
      tick(1'b1, 4'hE, 1'b1, 1'b0, 1'b0);
      expect_window(16'h3E3E, "win_3E3E");

      // reset in LOAD and in SCROLL
      load(64'h123, 3, 1'b0);
      mid_reset("rst_load");
      load(64'h78, 2, 1'b1);
      expect_window(16'h7878, "win_7878");
      pulse();
      mid_reset("rst_scroll");
      repeat (4) tick(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
      load(64'hABCD, 4, 1'b1);
      expect_window(16'hABCD, "win_ABCD");

`ifdef SCROLL_PAUSE_EN
      repeat (3) tick(1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
      expect_window(16'hABCD, "win_paused");
      tick(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
      expect_window(16'hBCDA, "win_unpaused");
`endif

      // randomized traffic against the model
      repeat (1500) begin
         tick($urandom_range(0, 5) == 0, 4'($urandom_range(0, 15)),
              $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
              $urandom_range(0, 2) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
